// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HALTED,
        FAULT
    } fetch_state_t;

    typedef enum logic [1:0] {
        PC_HOLD,
        PC_INC,
        PC_BRANCH,
        PC_BRANCH_RAW
    } pc_sel_t;

    localparam logic [31:0] NOP_INSTR          = 32'h0000_0013;
    localparam logic [31:0] PC_STEP            = 32'd4;
    localparam logic [31:0] DEFAULT_HALT_INSTR = 32'h0000_0073;

endpackage

// File: rtl/fetch_pc_sel.sv
// Next-PC multiplexer: hold, sequential step, or branch redirect (word-aligned or raw).
module fetch_pc_sel
    import fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] branch_target,
    input  pc_sel_t     sel,
    output logic [31:0] pc_next
);

    always_comb begin
        pc_next = pc;
        case (sel)
            PC_HOLD:       pc_next = pc;
            PC_INC:        pc_next = pc + PC_STEP;
            PC_BRANCH:     pc_next = {branch_target[31:2], 2'b00};
            PC_BRANCH_RAW: pc_next = branch_target;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, ram handshake, single-entry instruction register, branch and halt.
// Optional misaligned-branch trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          ADDR_W     = 5,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] HALT_INSTR = DEFAULT_HALT_INSTR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_enable,
    input  logic [31:0]       instr_in,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [31:0]       branch_target,
    output logic              fetch_req,
    output logic [ADDR_W-1:0] address_IM,
    output logic [31:0]       instr_out,
    output logic [31:0]       pc_out,
    output logic              instr_valid,
    output logic              halted
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic              fetch_fault
`endif
);

    fetch_state_t state_reg;
    logic [31:0]  pc_reg;
    logic [31:0]  pc_next;
    pc_sel_t      pc_sel;
    logic         branch_act;
    logic         capture;
    logic         is_halt;
    logic         misaligned;

    assign fetch_req  = (state_reg == REQ) && (!instr_valid || !stall);
    assign address_IM = pc_reg[ADDR_W+1:2];
    assign branch_act = branch_taken && (state_reg != HALTED);
    // A redirect in the same cycle always wins over the returning word.
    assign capture    = fetch_req && pc_enable && !branch_taken;
    assign is_halt    = (instr_in == HALT_INSTR);

`ifdef FETCH_MISALIGN_TRAP_EN
    assign misaligned = (branch_target[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        pc_sel = PC_HOLD;
        if (branch_act) begin
            pc_sel = misaligned ? PC_BRANCH_RAW : PC_BRANCH;
        end else if (capture && !is_halt) begin
            pc_sel = PC_INC;
        end
    end

    fetch_pc_sel u_pc_sel (
        .pc            (pc_reg),
        .branch_target (branch_target),
        .sel           (pc_sel),
        .pc_next       (pc_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            pc_reg      <= RESET_PC;
            instr_out   <= NOP_INSTR;
            pc_out      <= '0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            fetch_fault <= 1'b0;
`endif
        end else begin
            pc_reg <= pc_next;
            if (branch_act) begin
                instr_valid <= 1'b0;
                instr_out   <= NOP_INSTR;
`ifdef FETCH_MISALIGN_TRAP_EN
                state_reg   <= misaligned ? FAULT : REQ;
                fetch_fault <= misaligned;
`else
                state_reg   <= REQ;
`endif
            end else if (capture) begin
                instr_out   <= instr_in;
                pc_out      <= pc_reg;
                instr_valid <= 1'b1;
                if (is_halt) begin
                    state_reg <= HALTED;
                    halted    <= 1'b1;
                end
            end else begin
                if (instr_valid && !stall) begin
                    instr_valid <= 1'b0;
                end
                if (state_reg == IDLE) begin
                    state_reg <= REQ;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, PC-wrap sequence, and randomized run against a behavioural model.
module tb_fetch_unit;

`ifdef FETCH_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    localparam logic [31:0] HALT = 32'h0000_0073;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_enable;
    logic [31:0] instr_in;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;

    logic        fetch_req,   fetch_req_w,   fetch_req_z;
    logic [4:0]  address_IM,  address_IM_w,  address_IM_z;
    logic [31:0] instr_out,   instr_out_w,   instr_out_z;
    logic [31:0] pc_out,      pc_out_w,      pc_out_z;
    logic        instr_valid, instr_valid_w, instr_valid_z;
    logic        halted,      halted_w,      halted_z;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fetch_fault, fetch_fault_w, fetch_fault_z;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_unit #(.ADDR_W(5), .RESET_PC(32'h0000_0000), .HALT_INSTR(HALT)) dut (
        .clk(clk), .rst(rst), .pc_enable(pc_enable), .instr_in(instr_in), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target), .fetch_req(fetch_req),
        .address_IM(address_IM), .instr_out(instr_out), .pc_out(pc_out),
        .instr_valid(instr_valid), .halted(halted)
`ifdef FETCH_MISALIGN_TRAP_EN
        , .fetch_fault(fetch_fault)
`endif
    );

    fetch_unit #(.ADDR_W(5), .RESET_PC(32'h0000_007C), .HALT_INSTR(HALT)) dut_w (
        .clk(clk), .rst(rst), .pc_enable(pc_enable), .instr_in(instr_in), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target), .fetch_req(fetch_req_w),
        .address_IM(address_IM_w), .instr_out(instr_out_w), .pc_out(pc_out_w),
        .instr_valid(instr_valid_w), .halted(halted_w)
`ifdef FETCH_MISALIGN_TRAP_EN
        , .fetch_fault(fetch_fault_w)
`endif
    );

    fetch_unit #(.ADDR_W(5), .RESET_PC(32'hFFFF_FFFC), .HALT_INSTR(HALT)) dut_z (
        .clk(clk), .rst(rst), .pc_enable(pc_enable), .instr_in(instr_in), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target), .fetch_req(fetch_req_z),
        .address_IM(address_IM_z), .instr_out(instr_out_z), .pc_out(pc_out_z),
        .instr_valid(instr_valid_z), .halted(halted_z)
`ifdef FETCH_MISALIGN_TRAP_EN
        , .fetch_fault(fetch_fault_z)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Directed vector: inputs for one cycle, outputs expected during it and after its edge.
    typedef struct {
        logic        rst, pen, stall, br;
        logic [31:0] tgt, instr;
        logic        exp_req;
        logic [4:0]  exp_addr;
        logic        exp_v;
        logic [31:0] exp_ir, exp_pco;
        logic        exp_h, exp_fault;
    } vec_t;

    vec_t vq[$];

    // Behavioural model: architectural state described directly by the fetch rules.
    logic [31:0] m_pc, m_ir, m_pco;
    logic        m_v, m_h, m_fault, m_started;

    function automatic logic m_req();
        return m_started && !m_h && !m_fault && (!m_v || !stall);
    endfunction

    task automatic model_step(output logic took);
        logic req;
        took = 1'b0;
        req  = m_req();
        if (rst) begin
            m_pc = 32'h0; m_ir = NOP; m_pco = 32'h0;
            m_v = 0; m_h = 0; m_fault = 0; m_started = 0;
        end else if (branch_taken && !m_h) begin
            m_started = 1;
            m_v  = 0;
            m_ir = NOP;
            if (TRAP && branch_target[1:0] != 2'b00) begin
                m_pc = branch_target; m_fault = 1;
            end else begin
                m_pc = branch_target & 32'hFFFF_FFFC; m_fault = 0;
            end
        end else if (req && pc_enable) begin
            took  = 1'b1;
            m_ir  = instr_in;
            m_pco = m_pc;
            m_v   = 1;
            if (instr_in == HALT) m_h = 1;
            else m_pc = m_pc + 32'd4;
        end else begin
            if (m_v && !stall) m_v = 0;
            m_started = 1;
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        rst = v.rst; pc_enable = v.pen; stall = v.stall;
        branch_taken = v.br; branch_target = v.tgt; instr_in = v.instr;
        @(negedge clk);
        chk($sformatf("vec%0d fetch_req", idx), {31'b0, fetch_req}, {31'b0, v.exp_req});
        chk($sformatf("vec%0d address_IM", idx), {27'b0, address_IM}, {27'b0, v.exp_addr});
        @(posedge clk); #1;
        chk($sformatf("vec%0d instr_valid", idx), {31'b0, instr_valid}, {31'b0, v.exp_v});
        chk($sformatf("vec%0d instr_out", idx), instr_out, v.exp_ir);
        chk($sformatf("vec%0d pc_out", idx), pc_out, v.exp_pco);
        chk($sformatf("vec%0d halted", idx), {31'b0, halted}, {31'b0, v.exp_h});
`ifdef FETCH_MISALIGN_TRAP_EN
        chk($sformatf("vec%0d fetch_fault", idx), {31'b0, fetch_fault}, {31'b0, v.exp_fault});
`endif
        $display("vec %0d: rst=%0b pen=%0b stall=%0b br=%0b instr=%h -> valid=%0b instr_out=%h pc_out=%h halted=%0b",
                 idx, v.rst, v.pen, v.stall, v.br, v.instr, instr_valid, instr_out, pc_out, halted);
    endtask

    initial begin
        logic took;
        rst = 1; pc_enable = 0; stall = 0; branch_taken = 0; branch_target = 0; instr_in = 0;
        @(posedge clk); #1;

        //           rst pen stl br  tgt           instr          req    addr   v  ir            pco           h  fault
        vq.push_back('{1, 0, 0, 0, 32'h0,        32'h0,        1'b0,  5'd0,  0, NOP,          32'h0,        0, 0});
        vq.push_back('{1, 1, 0, 0, 32'h0,        32'h0,        1'b0,  5'd0,  0, NOP,          32'h0,        0, 0});
        vq.push_back('{0, 1, 0, 0, 32'h0,        32'h00A00093, 1'b0,  5'd0,  0, NOP,          32'h0,        0, 0});
        vq.push_back('{0, 1, 0, 0, 32'h0,        32'h00A00093, 1'b1,  5'd0,  1, 32'h00A00093, 32'h0,        0, 0});
        vq.push_back('{0, 1, 0, 0, 32'h0,        32'h00108113, 1'b1,  5'd1,  1, 32'h00108113, 32'h4,        0, 0});
        vq.push_back('{0, 1, 0, 0, 32'h0,        32'h00208193, 1'b1,  5'd2,  1, 32'h00208193, 32'h8,        0, 0});
        vq.push_back('{0, 1, 1, 0, 32'h0,        32'hDEADBEEF, 1'b0,  5'd3,  1, 32'h00208193, 32'h8,        0, 0});
        vq.push_back('{0, 1, 1, 0, 32'h0,        32'hDEADBEEF, 1'b0,  5'd3,  1, 32'h00208193, 32'h8,        0, 0});
        vq.push_back('{0, 1, 1, 0, 32'h0,        32'hDEADBEEF, 1'b0,  5'd3,  1, 32'h00208193, 32'h8,        0, 0});
        vq.push_back('{0, 1, 0, 0, 32'h0,        32'h00310213, 1'b1,  5'd3,  1, 32'h00310213, 32'hC,        0, 0});
        vq.push_back('{0, 1, 0, 1, 32'h22,       32'h11111111, 1'b1,  5'd4,  0, NOP,          32'hC,        0, TRAP});
        vq.push_back('{0, 0, 0, 0, 32'h0,        32'h0,        !TRAP, 5'd8,  0, NOP,          32'hC,        0, TRAP});
        vq.push_back('{0, 0, 0, 1, 32'h10,       32'h0,        !TRAP, 5'd8,  0, NOP,          32'hC,        0, 0});
        vq.push_back('{0, 1, 0, 0, 32'h0,        HALT,         1'b1,  5'd4,  1, HALT,         32'h10,       1, 0});
        vq.push_back('{0, 1, 0, 0, 32'h0,        32'h12345678, 1'b0,  5'd4,  0, HALT,         32'h10,       1, 0});
        vq.push_back('{0, 1, 0, 1, 32'h40,       32'h12345678, 1'b0,  5'd4,  0, HALT,         32'h10,       1, 0});
        vq.push_back('{0, 0, 0, 0, 32'h0,        32'h0,        1'b0,  5'd4,  0, HALT,         32'h10,       1, 0});
        vq.push_back('{1, 1, 0, 0, 32'h0,        32'h0,        1'b0,  5'd4,  0, NOP,          32'h0,        0, 0});
        vq.push_back('{0, 0, 0, 0, 32'h0,        32'h0,        1'b0,  5'd0,  0, NOP,          32'h0,        0, 0});
        vq.push_back('{0, 1, 0, 0, 32'h0,        32'h00500293, 1'b1,  5'd0,  1, 32'h00500293, 32'h0,        0, 0});

        foreach (vq[i]) run_vec(i, vq[i]);

        // Address wrap: word address 31 -> 0, and byte PC wrapping past 2^32.
        rst = 1; pc_enable = 0; branch_taken = 0; stall = 0; instr_in = NOP;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("wrap idle addr_w", {27'b0, address_IM_w}, 32'd31);
        @(posedge clk); #1;
        pc_enable = 1;
        @(negedge clk);
        chk("wrap addr_w before", {27'b0, address_IM_w}, 32'd31);
        chk("wrap addr_z before", {27'b0, address_IM_z}, 32'd31);
        @(posedge clk); #1;
        chk("wrap addr_w after", {27'b0, address_IM_w}, 32'd0);
        chk("wrap pc_out_w", pc_out_w, 32'h0000_007C);
        chk("wrap addr_z after", {27'b0, address_IM_z}, 32'd0);
        chk("wrap pc_out_z", pc_out_z, 32'hFFFF_FFFC);
        $display("wrap: addr_w=%0d pc_out_w=%h addr_z=%0d pc_out_z=%h", address_IM_w, pc_out_w, address_IM_z, pc_out_z);

        // Randomized run; first cycle forces reset so model and DUT align.
        for (int c = 0; c < 400; c++) begin
            rst           = (c == 0) || ($urandom_range(0, 79) == 0);
            pc_enable     = $urandom_range(0, 3) != 0;
            stall         = $urandom_range(0, 2) == 0;
            branch_taken  = $urandom_range(0, 7) == 0;
            branch_target = ($urandom & 32'hFFFF_FFFC) |
                            (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
            instr_in      = ($urandom_range(0, 29) == 0) ? HALT : $urandom;
            @(negedge clk);
            if (c > 0) begin
                chk("rand fetch_req", {31'b0, fetch_req}, {31'b0, m_req()});
                chk("rand address_IM", {27'b0, address_IM}, {27'b0, m_pc[6:2]});
            end
            model_step(took);
            @(posedge clk); #1;
            chk("rand instr_valid", {31'b0, instr_valid}, {31'b0, m_v});
            chk("rand instr_out", instr_out, m_ir);
            chk("rand pc_out", pc_out, m_pco);
            chk("rand halted", {31'b0, halted}, {31'b0, m_h});
`ifdef FETCH_MISALIGN_TRAP_EN
            chk("rand fetch_fault", {31'b0, fetch_fault}, {31'b0, m_fault});
`endif
            if (took) begin
                $display("rand %0d: capture instr=%h pc=%h halted=%0b", c, instr_out, pc_out, halted);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage directly upstream of the ram block's instruction port. It owns the program counter and drives the ram's word address (address_IM). It captures instr_out into a single-entry instruction register when the ram returns pc_enable, and presents that instruction to decode.
It also handles branch redirects, decode back-pressure (stall) and a halt instruction.

Parameters:
ADDR_W, 5, width of ram word address (address_IM)
RESET_PC, 32'h0000_0000, byte address loaded into PC on reset
HALT_INSTR, 32'h0000_0073, encoding that stops fetching once captured

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous, active-high reset
pc_enable  in  1  ram handshake; high = instr_in valid for the current address_IM this cycle
instr_in  in  32  instruction word from ram instr_out
stall  in  1  decode cannot accept instr_out this cycle
branch_taken  in  1  redirect request from execute (single-cycle pulse)
branch_target  in  32  redirect byte address
fetch_req  out  1  read request to ram instruction port
address_IM  out  ADDR_W  word address = pc[ADDR_W+1:2]
instr_out  out  32  registered instruction to decode
pc_out  out  32  byte address of instr_out
instr_valid  out  1  instr_out holds a live instruction
halted  out  1  HALT_INSTR captured; fetch stopped

Behaviour:
- Reset values (sync, rst high at posedge):
  - pc=RESET_PC, instr_out=32'h0000_0013 (NOP), pc_out=0.
  - instr_valid=0, halted=0, fetch_req=0, state=IDLE.
  - rst has priority over every other input, including mid-handshake and in HALTED.
- FSM states: IDLE, REQ, HALTED (plus FAULT under the optional feature).
  - IDLE -> REQ unconditionally after one cycle. fetch_req=0 in IDLE.
  - REQ: fetch_req = !instr_valid || !stall, combinational. address_IM is always pc[ADDR_W+1:2]; truncation wraps it mod 2^ADDR_W.
- Capture (REQ, fetch_req && pc_enable && !branch_taken) at posedge:
  - instr_out<=instr_in, pc_out<=pc, instr_valid<=1, pc<=pc+4 (wraps mod 2^32).
  - Latency: address presented in cycle N with pc_enable=1 gives instr_valid=1 in cycle N+1.
  - If instr_in==HALT_INSTR: still captured and presented, pc not advanced, state->HALTED, halted<=1.
- Consume: instr_valid && !stall with no capture that edge -> instr_valid<=0.
  - Capture and consume in the same edge: the new instruction replaces the old one and instr_valid stays 1. Back-to-back throughput is 1/cycle.
- Back-pressure: instr_valid && stall -> fetch_req=0. pc and instr_out are held, and pc_enable is ignored.
- Branch (branch_taken=1, any state except HALTED):
  - pc<=branch_target with bits [1:0] forced to 0, instr_valid<=0, instr_out<=NOP.
  - A coincident pc_enable is discarded. Branch beats capture and consume.
- HALTED: fetch_req=0, pc frozen, and branch_taken is ignored.
  - instr_out/instr_valid still drain normally on !stall.
  - Exit only via rst.
- pc_enable while fetch_req=0: ignored, no state change.

Optional Feature:
FETCH_MISALIGN_TRAP_EN
- Defined:
  - A branch_target with bits[1:0]!=0 moves the FSM to FAULT and leaves pc=branch_target unmodified.
  - Adds output fetch_fault (1 bit, reset 0), set and held in FAULT.
  - fetch_req=0 in FAULT. A later aligned branch_taken returns to REQ and clears fetch_fault. rst also clears it.
- Undefined: the low two bits are silently cleared as described above. There is no fetch_fault port and no FAULT state.

Decomposition:
- Package fetch_pkg:
  - state enum fetch_state_t {IDLE, REQ, HALTED, FAULT}.
  - Constants NOP_INSTR=32'h0000_0013, PC_STEP=4.
  - Default HALT_INSTR value.
- One sub-module, fetch_pc_sel: combinational next-PC mux (hold / pc+4 / aligned branch_target), instantiated once.
- FSM, instruction register and handshake stay in fetch_unit.

Test Plan:
- Reset: rst=1 for 2 cycles -> instr_valid=0, fetch_req=0, address_IM=0, instr_out=32'h13. Cycle after IDLE: fetch_req=1.
- Streaming: pc_enable=1 every cycle, stall=0, instr_in=32'h00A00093,32'h00108113,... -> instr_valid from the 2nd REQ cycle; pc_out=0,4,8; address_IM=0,1,2.
- Wrap: RESET_PC=32'h7C, capture once -> pc=32'h80, address_IM wraps 31->0. Also RESET_PC=32'hFFFF_FFFC capture -> pc=0.
- Stall: instr_valid=1, stall=1 for 3 cycles with pc_enable=1 -> fetch_req=0, instr_out and pc_out unchanged. Release stall -> next instruction captured the same edge.
- Branch vs capture: branch_taken=1, branch_target=32'h0000_0022, pc_enable=1 same cycle -> instr_in discarded, instr_valid=0, pc=32'h20.
  - With FETCH_MISALIGN_TRAP_EN: fetch_fault=1, fetch_req=0.
  - Then branch to 32'h10 -> fault clears.
- Halt: capture instr_in=32'h00000073 -> halted=1 next cycle, fetch_req=0, a later branch_taken is ignored. rst -> halted=0, pc=RESET_PC.
